sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
Serial-in/parallel-out receiver, the receive end of the team's 4-bit right-shifting parallel-load shift register. That register's serial stream leaves LSB first on q[0]. This block assembles WIDTH-bit words from a qualified serial bit stream, with resynchronisation on a frame-start strobe. Completed words go into a one-entry output buffer with a valid/ready handshake, and a sticky overflow flag reports dropped words.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
LSB_FIRST, 1, 1 = first received bit lands in out_data[0]; 0 = first received bit lands in out_data[WIDTH-1].

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
ser_in  input  1  serial data bit, sampled only when ser_valid=1.
ser_valid  input  1  qualifies ser_in for this cycle.
frame_start  input  1  synchronous word-boundary resync; discards any partial word.
out_data  output  WIDTH  buffered parallel word; stable while out_valid=1 and out_ready=0.
out_valid  output  1  out_data holds an unconsumed word.
out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
overflow  output  1  sticky: a completed word was dropped because the buffer was full.
clear_overflow  input  1  synchronous clear of overflow.
bit_cnt  output  $clog2(WIDTH)  number of bits held in the partial word (debug/status).

Behaviour:
- Reset, asynchronous: shift register, bit_cnt, out_data, out_valid and overflow all go to 0 immediately. Reset mid-word discards the partial word and any buffered word.
- Shift on ser_valid=1:
  - LSB_FIRST=1: sreg <= {ser_in, sreg[WIDTH-1:1]}.
  - LSB_FIRST=0: sreg <= {sreg[WIDTH-2:0], ser_in}.
  - With ser_valid=0, sreg and bit_cnt hold; gaps between bits are unlimited.
- bit_cnt increments on each accepted bit. On the bit where bit_cnt==WIDTH-1 it wraps to 0 and the word completes; the completed word is the post-shift sreg value.
- frame_start=1 with ser_valid=0: bit_cnt <= 0 and the partial word is discarded. out_valid, out_data and overflow are unaffected.
- frame_start=1 with ser_valid=1: the partial word is discarded and the current bit becomes bit 0 (bit_cnt <= 1). With WIDTH=... the word can never complete in that cycle, since WIDTH>=2.
- Output buffer, two states:
  - EMPTY (out_valid=0) -> FULL on word completion.
  - FULL -> EMPTY on out_ready=1 with no completion in the same cycle.
  - FULL with out_ready=1 and a completion in the same cycle: out_data loads the new word and the state stays FULL. This gives full throughput, no bubble.
- Latency: out_valid=1 and out_data are visible in the cycle after the edge that sampled the last bit.
- Overflow: a completion while FULL and out_ready=0 drops the new word. The buffered word is kept unchanged, overflow is set, and bit_cnt still wraps to 0.
- clear_overflow clears overflow on the next edge. If a set and a clear occur in the same cycle, the set wins.
- out_ready while EMPTY is ignored.

Decomposition:
- Shared package/include holds the bit-order constants BIT_ORDER_LSB_FIRST=1 and BIT_ORDER_MSB_FIRST=0, used by this block and the parallel-load shift register.
- One natural sub-module: deser_out_buf, the one-entry valid/ready holding register plus overflow logic, parameterised by WIDTH. The shift/count logic stays in the top module.

Test Plan:
1. Reset mid-word: WIDTH=4, LSB_FIRST=1; feed bits 1,0; assert reset -> bit_cnt=0, out_valid=0, overflow=0 immediately. Then bits 1,1,0,1 -> out_data=4'b1011.
2. Loopback: shift register loaded with 4'b1011, shifted 4 cycles, q[0] drives ser_in with ser_valid=1, out_ready=1 -> out_valid pulses one cycle after the 4th bit with out_data=4'b1011. Repeat with LSB_FIRST=0 and the same stream -> 4'b1101.
3. Gapped input: bits 0,1,1,0 with ser_valid low for 3 cycles between each -> out_data=4'b0110; out_valid rises only after the 4th valid bit.
4. Back-to-back with stall: words 4'hA then 4'h5 with out_ready=0 -> out_data holds 4'hA and overflow=1. Set clear_overflow and out_ready=1 -> overflow=0 and out_valid=0 next cycle. Simultaneous pop+complete on 4'h3 -> out_data=4'h3, out_valid stays 1.
5. Resync: bits 1,1 then frame_start with ser_valid=1, ser_in=0, then 1,0,1 -> out_data=4'b1010; the pre-resync bits are never output. frame_start with ser_valid=0 mid-word -> bit_cnt=0.
6. Set/clear collision: overflow condition and clear_overflow in the same cycle -> overflow=1.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
// ============================================================================
//  Module      : sipo_deserializer_pkg
//  Description : Bit-order constants shared by the serial receiver and the
//                parallel-load shift register, plus the output-buffer states.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sipo_deserializer_pkg;

  // Bit order on the serial link, as seen by both ends.
  localparam int BIT_ORDER_LSB_FIRST = 1;
  localparam int BIT_ORDER_MSB_FIRST = 0;

  // One-entry output buffer occupancy.
  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage : sipo_deserializer_pkg

`default_nettype wire

// File: rtl/deser_out_buf.sv
// ============================================================================
//  Module      : deser_out_buf
//  Description : One-entry valid/ready holding register for completed words,
//                with a sticky overflow flag for words dropped while full.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module deser_out_buf
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             word_done,
  input  logic [WIDTH-1:0] word_in,
  input  logic             out_ready,
  input  logic             clear_overflow,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overflow
);

  buf_state_e r_state;
  logic       w_drop;

  // A completion that finds the buffer occupied and not being drained is lost.
  assign w_drop = (r_state == BUF_FULL) && word_done && !out_ready;

  // Buffer state machine with registered data/valid; overflow set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= BUF_EMPTY;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          // out_ready is irrelevant here: nothing to hand over.
          if (word_done) begin
            out_data  <= word_in;
            out_valid <= 1'b1;
            r_state   <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (out_ready) begin
            if (word_done) begin
              // Pop and refill in one edge keeps the stream bubble-free.
              out_data <= word_in;
            end else begin
              out_valid <= 1'b0;
              r_state   <= BUF_EMPTY;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          r_state   <= BUF_EMPTY;
        end
      endcase

      if (w_drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule : deser_out_buf

`default_nettype wire

// File: rtl/sipo_deserializer.sv
// ============================================================================
//  Module      : sipo_deserializer
//  Description : Serial-in/parallel-out receiver. Assembles WIDTH-bit words
//                from a qualified bit stream, resyncs on frame_start and
//                hands completed words to a one-entry valid/ready buffer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = BIT_ORDER_LSB_FIRST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  input  logic                     frame_start,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  input  logic                     clear_overflow,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int                c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [WIDTH-1:0]   r_sreg;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [WIDTH-1:0]   w_shift_base;
  logic [WIDTH-1:0]   w_sreg_next;
  logic               w_word_done;

  // A resync starts the new word from a clean register so no stale bits linger.
  assign w_shift_base = frame_start ? '0 : r_sreg;

  if (LSB_FIRST == BIT_ORDER_LSB_FIRST) begin : g_lsb_first
    // First bit received ends up in bit 0 after WIDTH shifts.
    assign w_sreg_next = {ser_in, w_shift_base[WIDTH-1:1]};
  end else begin : g_msb_first
    // First bit received ends up in bit WIDTH-1 after WIDTH shifts.
    assign w_sreg_next = {w_shift_base[WIDTH-2:0], ser_in};
  end

  // A resync bit is always bit 0, so it can never complete a word.
  assign w_word_done = ser_valid && !frame_start && (r_bit_cnt == c_last_bit);

  // Shift register and bit counter; holds across gaps in ser_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (ser_valid) begin
      r_sreg <= w_sreg_next;
      if (frame_start) begin
        r_bit_cnt <= c_cnt_one;
      end else if (w_word_done) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end else if (frame_start) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end
  end

  assign bit_cnt = r_bit_cnt;

  deser_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk            (clk),
    .reset          (reset),
    .word_done      (w_word_done),
    .word_in        (w_sreg_next),
    .out_ready      (out_ready),
    .clear_overflow (clear_overflow),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .overflow       (overflow)
  );

endmodule : sipo_deserializer

`default_nettype wire
